// File: rtl/app_line_echo.sv
// app_line_echo
//   Application-side console front-end for the CDC bulk path. Bytes arriving
//   on the OUT stream are collected into a local line buffer. When a CR or LF
//   terminator arrives, or the buffer fills, the buffered line is sent back on
//   the IN stream followed by CR LF. An LF that directly follows a CR
//   terminator is swallowed, so CR LF input produces a single echo.
//
// Ports
//   app_clk_i    application clock (rising edge)
//   rstn         asynchronous active-low reset
//   out_data_i   OUT byte             out_valid_i  OUT byte valid
//   out_ready_o  OUT byte accept (registered; high only while collecting)
//   in_data_o    IN byte              in_valid_o   IN byte valid (registered)
//   in_ready_i   IN byte consumed when in_valid_o is high
//   line_cnt_o   number of lines echoed, wraps at 16 bits
//   busy_o       high while not collecting (echo in progress)
module app_line_echo #(
  parameter int LINE_MAX  = 64,
  parameter bit UPPERCASE = 1'b0
) (
  input  logic        app_clk_i,
  input  logic        rstn,
  input  logic [7:0]  out_data_i,
  input  logic        out_valid_i,
  output logic        out_ready_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  output logic [15:0] line_cnt_o,
  output logic        busy_o
);

  localparam int PTR_W  = $clog2(LINE_MAX + 1);
  localparam int ADDR_W = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(LINE_MAX);
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;

  typedef enum logic [2:0] {
    ST_RX,
    ST_LOAD,
    ST_SEND,
    ST_CR,
    ST_LF
  } state_t;

  state_t            state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              last_cr;

  logic [7:0]        line_buf [LINE_MAX];

  logic              out_acc;
  logic              in_acc;
  logic              is_term;
  logic              lf_drop;
  logic              wr_en;
  logic [7:0]        wr_byte;
  logic [PTR_W-1:0]  wr_ptr_nxt;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  function automatic logic [7:0] map_case(input logic [7:0] b);
    if (UPPERCASE && (b >= 8'h61) && (b <= 8'h7A)) begin
      return b - 8'h20;
    end
    return b;
  endfunction

  assign out_acc    = (state == ST_RX) && out_valid_i && out_ready_o;
  assign in_acc     = in_valid_o && in_ready_i;
  assign is_term    = (out_data_i == CHR_CR) || (out_data_i == CHR_LF);
  // LF completing a CR LF pair on an otherwise empty line is not a new line.
  assign lf_drop    = (out_data_i == CHR_LF) && (wr_ptr == '0) && last_cr;
  assign wr_en      = out_acc && !is_term;
  assign wr_byte    = map_case(out_data_i);
  assign wr_ptr_nxt = wr_ptr + 1'b1;
  assign rd_ptr_nxt = rd_ptr + 1'b1;
  // Writes only happen while wr_ptr < LINE_MAX, so the low bits address the buffer.
  assign wr_addr    = wr_ptr[ADDR_W-1:0];
  assign rd_addr    = rd_ptr[ADDR_W-1:0];

  // Line storage: plain synchronous RAM, contents are never reset.
  always_ff @(posedge app_clk_i) begin
    if (wr_en) begin
      line_buf[wr_addr] <= wr_byte;
    end
  end

  always_ff @(posedge app_clk_i or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_RX;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      last_cr     <= 1'b0;
      out_ready_o <= 1'b0;
      in_valid_o  <= 1'b0;
      in_data_o   <= 8'h00;
      line_cnt_o  <= 16'h0000;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        ST_RX: begin
          out_ready_o <= 1'b1;
          if (out_acc) begin
            if (lf_drop) begin
              last_cr <= 1'b0;
            end else if (is_term) begin
              last_cr     <= (out_data_i == CHR_CR);
              out_ready_o <= 1'b0;
              busy_o      <= 1'b1;
              if (wr_ptr != '0) begin
                state <= ST_LOAD;
              end else begin
                // Empty line: go straight to the CR LF trailer.
                state      <= ST_CR;
                in_data_o  <= CHR_CR;
                in_valid_o <= 1'b1;
              end
            end else begin
              last_cr <= 1'b0;
              wr_ptr  <= wr_ptr_nxt;
              // Full buffer: flush it as a complete line.
              if (wr_ptr_nxt == PTR_FULL) begin
                state       <= ST_LOAD;
                out_ready_o <= 1'b0;
                busy_o      <= 1'b1;
              end
            end
          end
        end
        ST_LOAD: begin
          in_data_o  <= line_buf[rd_addr];
          in_valid_o <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: begin
          if (in_acc) begin
            rd_ptr <= rd_ptr_nxt;
            if (rd_ptr_nxt == wr_ptr) begin
              state      <= ST_CR;
              in_data_o  <= CHR_CR;
              in_valid_o <= 1'b1;
            end else begin
              state      <= ST_LOAD;
              in_valid_o <= 1'b0;
            end
          end
        end
        ST_CR: begin
          if (in_acc) begin
            state     <= ST_LF;
            in_data_o <= CHR_LF;
          end
        end
        ST_LF: begin
          if (in_acc) begin
            state       <= ST_RX;
            in_valid_o  <= 1'b0;
            line_cnt_o  <= line_cnt_o + 16'h0001;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            busy_o      <= 1'b0;
            out_ready_o <= 1'b1;
          end
        end
        default: begin
          state <= ST_RX;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_app_line_echo.sv
// Bench for app_line_echo: two instances (64-byte buffer, no case mapping;
// 4-byte buffer, uppercase mapping) driven with directed and random byte
// streams. A line-level reference model predicts the IN stream and line count.
module tb_app_line_echo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [7:0]  out_data  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [7:0]  in_data   [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [15:0] line_cnt  [2];
  logic        busy      [2];

  app_line_echo #(.LINE_MAX(64), .UPPERCASE(1'b0)) dut0 (
    .app_clk_i(clk), .rstn(rstn),
    .out_data_i(out_data[0]), .out_valid_i(out_valid[0]), .out_ready_o(out_ready[0]),
    .in_data_o(in_data[0]), .in_valid_o(in_valid[0]), .in_ready_i(in_ready[0]),
    .line_cnt_o(line_cnt[0]), .busy_o(busy[0])
  );

  app_line_echo #(.LINE_MAX(4), .UPPERCASE(1'b1)) dut1 (
    .app_clk_i(clk), .rstn(rstn),
    .out_data_i(out_data[1]), .out_valid_i(out_valid[1]), .out_ready_o(out_ready[1]),
    .in_data_o(in_data[1]), .in_valid_o(in_valid[1]), .in_ready_i(in_ready[1]),
    .line_cnt_o(line_cnt[1]), .busy_o(busy[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [7:0] exp_mem [2][4096];
  int         exp_n   [2] = '{0, 0};
  int         chk_n   [2] = '{0, 0};
  logic [7:0] mline   [2][256];
  int         mlen    [2] = '{0, 0};
  bit         mlast_cr[2] = '{0, 0};
  int         mcnt    [2] = '{0, 0};

  // Monitor state
  logic [7:0] got_mem [2][4096];
  int         got_n   [2] = '{0, 0};
  int         stab_err[2] = '{0, 0};
  int         ovl_err [2] = '{0, 0};
  logic       pv [2] = '{0, 0};
  logic       pr [2] = '{0, 0};
  logic [7:0] pd [2] = '{0, 0};

  int bp_mode [2] = '{0, 0};

  task automatic exp_push(input int k, input logic [7:0] b);
    if (exp_n[k] < 4096) begin
      exp_mem[k][exp_n[k]] = b;
      exp_n[k]++;
    end
  endtask

  task automatic model_emit(input int k);
    for (int i = 0; i < mlen[k]; i++) exp_push(k, mline[k][i]);
    exp_push(k, 8'h0D);
    exp_push(k, 8'h0A);
    mlen[k] = 0;
    mcnt[k] = (mcnt[k] + 1) % 65536;
  endtask

  task automatic model_byte(input int k, input logic [7:0] b);
    int lmax;
    lmax = (k == 0) ? 64 : 4;
    if (b == 8'h0A && mlen[k] == 0 && mlast_cr[k]) begin
      mlast_cr[k] = 1'b0;
    end else if (b == 8'h0D || b == 8'h0A) begin
      mlast_cr[k] = (b == 8'h0D);
      model_emit(k);
    end else begin
      mlast_cr[k] = 1'b0;
      mline[k][mlen[k]] = (k == 1 && b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
      mlen[k]++;
      if (mlen[k] == lmax) model_emit(k);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      exp_n[k] = 0; chk_n[k] = 0; mlen[k] = 0; mlast_cr[k] = 1'b0; mcnt[k] = 0;
    end
  endtask

  // IN-side back-pressure, driven just after the active edge
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      case (bp_mode[k])
        0:       in_ready[k] = 1'b1;
        1:       in_ready[k] = 1'($urandom % 2);
        default: in_ready[k] = 1'b0;
      endcase
    end
  end

  // Sample on the falling edge: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        got_n[k] = 0;
        pv[k] = 1'b0;
      end else begin
        if (pv[k] && !pr[k] && !(in_valid[k] && in_data[k] == pd[k])) stab_err[k]++;
        if (out_ready[k] && (in_valid[k] || busy[k])) ovl_err[k]++;
        if (in_valid[k] && in_ready[k] && got_n[k] < 4096) begin
          got_mem[k][got_n[k]] = in_data[k];
          got_n[k]++;
        end
        pv[k] = in_valid[k];
        pr[k] = in_ready[k];
        pd[k] = in_data[k];
      end
    end
  end

  task automatic send_byte(input int k, input logic [7:0] b);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    out_data[k]  = b;
    out_valid[k] = 1'b1;
    forever begin
      @(negedge clk);
      if (out_ready[k]) break;
      n++;
      if (n > 3000) begin
        check($sformatf("accept_timeout_%0d", k), 32'(n), 0);
        out_valid[k] = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    out_valid[k] = 1'b0;
    model_byte(k, b);
  endtask

  task automatic send_str(input int k, input string s);
    for (int i = 0; i < s.len(); i++) send_byte(k, s[i]);
  endtask

  task automatic drain(input int k, input string tag);
    int n;
    n = 0;
    while (!(got_n[k] == exp_n[k] && !busy[k]) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(n < 5000), 1);
    check({tag, "_len"}, 32'(got_n[k]), 32'(exp_n[k]));
    for (int i = chk_n[k]; i < exp_n[k] && i < got_n[k]; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_mem[k][i]), 32'(exp_mem[k][i]));
    chk_n[k] = (got_n[k] > exp_n[k]) ? got_n[k] : exp_n[k];
    check({tag, "_cnt"}, 32'(line_cnt[k]), 32'(mcnt[k]));
    check({tag, "_busy"}, 32'(busy[k]), 0);
    check({tag, "_oready"}, 32'(out_ready[k]), 1);
  endtask

  task automatic wait_valid(input int k, input string tag);
    int n;
    n = 0;
    while (!in_valid[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_seen"}, 32'(in_valid[k]), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_oready%0d", tag, k), 32'(out_ready[k]), 0);
      check($sformatf("%s_ivalid%0d", tag, k), 32'(in_valid[k]), 0);
      check($sformatf("%s_idata%0d", tag, k), 32'(in_data[k]), 0);
      check($sformatf("%s_cnt%0d", tag, k), 32'(line_cnt[k]), 0);
      check($sformatf("%s_busy%0d", tag, k), 32'(busy[k]), 0);
    end
  endtask

  function automatic logic [7:0] rand_byte();
    int x;
    x = int'($urandom % 16);
    if (x < 2) return 8'h0D;
    if (x == 2) return 8'h0A;
    if (x == 3) return 8'h7B;
    if (x < 7) return 8'h41 + 8'($urandom % 26);
    return 8'h61 + 8'($urandom % 26);
  endfunction

  logic [7:0] held;

  initial begin
    rstn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      out_data[k] = 8'h00;
      out_valid[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rstn = 1'b1;
    #1;
    check("por_oready_hold", 32'(out_ready[0]), 0);
    @(negedge clk);
    check("por_oready_rise", 32'(out_ready[0]), 1);

    // Directed lines
    send_str(0, "ab\x0d");
    drain(0, "ab_cr");
    check("ab_cr_lines", 32'(line_cnt[0]), 1);
    send_str(0, "\x0d\x0ax\x0a");
    drain(0, "crlf_x_lf");
    check("crlf_x_lf_lines", 32'(line_cnt[0]), 3);
    send_str(1, "aZ{\x0d");
    drain(1, "upper");
    send_str(1, "123456\x0d");
    drain(1, "flush");
    check("flush_lines", 32'(line_cnt[1]), 3);

    // Stall the IN side during SEND
    bp_mode[0] = 2;
    send_str(0, "hi\x0d");
    wait_valid(0, "hold");
    held = in_data[0];
    check("hold_first", 32'(held), 32'h68);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold_valid%0d", i), 32'(in_valid[0]), 1);
      check($sformatf("hold_data%0d", i), 32'(in_data[0]), 32'(held));
    end
    check("hold_busy", 32'(busy[0]), 1);
    check("hold_oready", 32'(out_ready[0]), 0);
    bp_mode[0] = 1;
    drain(0, "hold");

    // Random streams under random back-pressure
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 2; k++) begin
        bp_mode[k] = (r % 3 == 0) ? 0 : 1;
        for (int i = 0; i < 25; i++) send_byte(k, rand_byte());
        send_byte(k, 8'h0D);
        drain(k, $sformatf("rnd%0d_%0d", r, k));
      end
    end

    // Reset in the middle of an echo
    bp_mode[0] = 2;
    send_str(0, "abcdef\x0d");
    wait_valid(0, "mid");
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (3) @(negedge clk);
    model_reset();
    rstn = 1'b1;
    #1;
    check("mid_oready_hold", 32'(out_ready[0]), 0);
    @(negedge clk);
    check("mid_oready_rise", 32'(out_ready[0]), 1);
    bp_mode[0] = 1;
    send_str(0, "q\x0d");
    drain(0, "after_rst");
    check("after_rst_lines", 32'(line_cnt[0]), 1);
    check("after_rst_len", 32'(got_n[0]), 3);

    for (int k = 0; k < 2; k++) begin
      check($sformatf("stable_%0d", k), 32'(stab_err[k]), 0);
      check($sformatf("no_overlap_%0d", k), 32'(ovl_err[k]), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
